// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the memory-access stage
package cpu_pkg;
   localparam int N = 32;
   localparam logic [1:0] WB_SEL_PC  = 2'b00;
   localparam logic [1:0] WB_SEL_MEM = 2'b10;
   localparam logic [1:0] WB_SEL_EXE = 2'b11;
   typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} mem_state_t;
   typedef struct packed {
      logic [N-1:0] exe_out;
      logic [N-1:0] mem_out;
      logic [N-1:0] pc_inc4;
      logic [4:0]   rx;
      logic [1:0]   wb_data_sel;
      logic         wb_reg_sel;
      logic         reg_write;
   } mem_wb_t;
endpackage

// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg: MEM/WB pipeline register; fields hold when not loaded
module mem_wb_pipe_reg
   import cpu_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    load,
   input  mem_wb_t d,
   output logic    valid,
   output mem_wb_t q
);
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         q     <= '0;
      end else begin
         valid <= load;
         if (load) q <= d;
      end
   end
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM stage with one outstanding word load/store via req/ack handshake
module mem_access
   import cpu_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] exeOut,
   input  logic [N-1:0] StoreData,
   input  logic         MemRead,
   input  logic         MemWrite,
   input  logic [N-1:0] PCInc4,
   input  logic [4:0]   Rx,
   input  logic [1:0]   WbDataSel,
   input  logic         WbRegSel,
   input  logic         RegWrite,
   output logic         mem_req,
   output logic         mem_we,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   input  logic         mem_ack,
   input  logic         mem_rvalid,
   input  logic [N-1:0] mem_rdata,
   output logic         wb_valid,
   output logic [N-1:0] wb_exeOut,
   output logic [N-1:0] wb_MemOut,
   output logic [N-1:0] wb_PCInc4,
   output logic [4:0]   wb_Rx,
   output logic [1:0]   wb_WbDataSel,
   output logic         wb_WbRegSel,
   output logic         wb_RegWrite
);
   mem_state_t state;
   mem_wb_t    hold, in_fields, d, q;
   logic       load;
   assign in_ready  = state == IDLE;
   assign in_fields = '{exe_out: exeOut, mem_out: '0, pc_inc4: PCInc4, rx: Rx,
                        wb_data_sel: WbDataSel, wb_reg_sel: WbRegSel, reg_write: RegWrite};
   assign load = in_ready ? in_valid && !(MemRead || MemWrite) :
                 state == REQ ? mem_ack && (mem_we || mem_rvalid) : mem_rvalid;
   always_comb begin
      d         = hold;
      d.mem_out = mem_we ? '0 : mem_rdata;
      if (in_ready) d = in_fields;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         hold      <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid && (MemRead || MemWrite)) begin
               state     <= REQ;
               mem_req   <= 1'b1;
               mem_we    <= MemWrite;
               mem_addr  <= {exeOut[N-1:2], 2'b00};
               mem_wdata <= StoreData;
               hold      <= in_fields;
            end
            // a load whose data arrives with the ack completes without WAIT_RD
            REQ: if (mem_ack) begin
               mem_req <= 1'b0;
               state   <= mem_we || mem_rvalid ? IDLE : WAIT_RD;
            end
            WAIT_RD: if (mem_rvalid) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   mem_wb_pipe_reg u_mem_wb (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .d    (d),
      .valid(wb_valid),
      .q    (q)
   );
   assign wb_exeOut    = q.exe_out;
   assign wb_MemOut    = q.mem_out;
   assign wb_PCInc4    = q.pc_inc4;
   assign wb_Rx        = q.rx;
   assign wb_WbDataSel = q.wb_data_sel;
   assign wb_WbRegSel  = q.wb_reg_sel;
   assign wb_RegWrite  = q.reg_write & wb_valid;
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the pipelined CPU: sits between execute and write-back. Accepts one instruction per cycle from the EX/MEM boundary, performs at most one outstanding word load or store through a request/acknowledge handshake to the external memory controller, and registers results into the MEM/WB pipeline register consumed by the write-back stage. Stalls upstream while a memory operation is in flight.

## Interface
- N, 32, data and address width
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  EX/MEM instruction present
- in_ready  output  1  stage accepts instruction this cycle; equals (state == IDLE)
- exeOut  input  N  ALU result; memory word address for loads/stores
- StoreData  input  N  store data (rt value)
- MemRead  input  1  instruction is a load
- MemWrite  input  1  instruction is a store; MemRead & MemWrite together is illegal
- PCInc4  input  N  PC+4 of instruction
- Rx  input  5  destination register from opcode
- WbDataSel  input  2  write-back data select, forwarded unchanged
- WbRegSel  input  1  write-back register select, forwarded unchanged
- RegWrite  input  1  instruction writes register file
- mem_req  output  1  memory request, held until accepted
- mem_we  output  1  1 = store, 0 = load
- mem_addr  output  N  word address ({exeOut[N-1:2], 2'b00})
- mem_wdata  output  N  store data
- mem_ack  input  1  controller accepts request this cycle
- mem_rvalid  input  1  load data valid
- mem_rdata  input  N  load data
- wb_valid  output  1  MEM/WB register holds a completed instruction
- wb_exeOut, wb_MemOut, wb_PCInc4  output  N  registered to write-back
- wb_Rx  output  5; wb_WbDataSel  output  2; wb_WbRegSel  output  1
- wb_RegWrite  output  1  registered RegWrite gated by wb_valid

## Operation
- FSM states: IDLE, REQ, WAIT_RD.
- IDLE, in_valid, no memory op: MEM/WB loads all fields next edge, wb_valid=1, wb_MemOut=0; stay IDLE.
- IDLE, in_valid, MemRead or MemWrite: capture all fields into hold register; go REQ; no wb_valid this edge.
- REQ: mem_req=1 with mem_we/addr/wdata driven from hold register, stable until mem_ack.
  - ack & store: complete; go IDLE.
  - ack & load & mem_rvalid same cycle: complete with mem_rdata; go IDLE.
  - ack & load, no rvalid: go WAIT_RD (mem_req drops next cycle).
  - no ack: stay REQ.
- WAIT_RD: on mem_rvalid, complete with mem_rdata; go IDLE.
- Completion: MEM/WB loads held fields (wb_MemOut = rdata for loads, 0 for stores), wb_valid=1 for exactly one cycle.
- Cycles without completion: wb_valid=0, wb_RegWrite=0; data fields hold previous values.
- mem_rvalid/mem_ack in IDLE are ignored (stale response after reset).
- Only one memory operation outstanding; exeOut[1:0] ignored.

## Timing
- Reset: state IDLE; mem_req, mem_we, mem_addr, mem_wdata, all wb_* outputs 0; in_ready=1 the cycle after reset edge.
- Non-memory latency: 1 cycle, throughput 1/cycle.
- Store: accept at T, mem_req from T+1, ack at T+k, wb_valid at T+k+1.
- Load: ack at T+k, rvalid at T+m (m ≥ k), wb_valid at T+m+1.
- in_ready low from cycle after memory accept through completion cycle; returns high the cycle after completion edge, i.e. minimum load/store occupancy 2 cycles.
- Upstream holds inputs stable while in_ready=0.
- rst mid-operation: FSM to IDLE and mem_req=0 next edge; in-flight op abandoned, no wb_valid.

## Structure
- cpu_pkg: mem_state_t enum (IDLE, REQ, WAIT_RD); WB_SEL_PC=2'b00, WB_SEL_MEM=2'b10, WB_SEL_EXE=2'b11; mem_wb_t packed struct of MEM/WB fields.
- Sub-module mem_wb_pipe_reg: MEM/WB register with load-enable and valid, sync reset.

## Test plan
- Reset: rst=1 two cycles with mem_ack=1, mem_rvalid=1 -> all outputs 0, in_ready=1, no mem_req.
- ALU stream: 3 back-to-back non-memory ops exeOut=0x10,0x20,0x30 -> wb_valid 3 consecutive cycles, wb_exeOut in order, mem_req never high.
- Load, delayed: MemRead, exeOut=0x1003, ack after 2 cycles, rvalid 3 cycles later with 0xDEADBEEF -> mem_addr=0x1000 stable until ack, wb_MemOut=0xDEADBEEF, wb_valid one pulse, in_ready low throughout.
- Load, ack and rvalid same cycle with 0x12345678 -> no WAIT_RD, wb_valid next cycle.
- Store: MemWrite, exeOut=0x2000, StoreData=0xA5A5A5A5, ack after 1 cycle -> mem_we=1, mem_wdata=0xA5A5A5A5, wb_RegWrite=0, wb_valid one cycle after ack.
- Reset during WAIT_RD, then rvalid=1 -> mem_req=0, no wb_valid, next instruction accepted normally.
